// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow input against clk_in.
// Optional min/max period tracking is enabled with `define CLK_METER_MINMAX_EN.
module clk_period_meter #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned EXP_DIV  = 10,
    parameter int unsigned TOL      = 0,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             overflow,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period
);

    localparam int unsigned MC_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [MC_W-1:0]  LOCK_M  = MC_W'(LOCK_CNT);
    localparam logic [MC_W-1:0]  MC_ONE  = MC_W'(1);

    localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXP_DIV);
    localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t state_q;

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic             rise;
    logic             fall;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;
    logic             meas_valid_q;
    logic             locked_q;
    logic             overflow_q;
    logic [MC_W-1:0]  mcnt_q;

    logic signed [CNT_W:0] diff_d;
    logic signed [CNT_W:0] adiff_d;
    logic                  match_d;
    logic [MC_W-1:0]       mcnt_d;
    logic                  meas_d;

    assign rise   = sync2_q & ~prev_q;
    assign fall   = ~sync2_q & prev_q;
    assign meas_d = (state_q == MEASURE) & rise;

    // Two-flop synchroniser followed by the edge-detect register
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Lock match test on the period about to be published
    always_comb begin
        diff_d  = $signed({1'b0, cnt_q}) - EXP_S;
        adiff_d = (diff_d < 0) ? -diff_d : diff_d;
        match_d = (adiff_d <= TOL_S);
        mcnt_d  = (mcnt_q == LOCK_M) ? mcnt_q : mcnt_q + MC_ONE;
    end

    // Measurement FSM with registered results and lock tracking
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            period_q     <= '0;
            high_q       <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            overflow_q   <= 1'b0;
            mcnt_q       <= '0;
        end else begin
            meas_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        cnt_q   <= CNT_ONE;
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (meas_d) begin
                        period_q     <= cnt_q;
                        meas_valid_q <= 1'b1;
                        cnt_q        <= CNT_ONE;
                        if (match_d) begin
                            mcnt_q   <= mcnt_d;
                            locked_q <= (mcnt_d == LOCK_M);
                        end else begin
                            mcnt_q   <= '0;
                            locked_q <= 1'b0;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        // Saturated: results hold, re-arm on a later rise
                        overflow_q <= 1'b1;
                        locked_q   <= 1'b0;
                        mcnt_q     <= '0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (fall) begin
                            high_q <= cnt_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign overflow   = overflow_q;

`ifdef CLK_METER_MINMAX_EN
    logic [CNT_W-1:0] min_q;
    logic [CNT_W-1:0] max_q;

    // Extremes of every published period since reset
    always_ff @(posedge clk_in) begin
        if (rst) begin
            min_q <= '1;
            max_q <= '0;
        end else if (meas_d) begin
            if (cnt_q < min_q) begin
                min_q <= cnt_q;
            end
            if (cnt_q > max_q) begin
                max_q <= cnt_q;
            end
        end
    end

    assign min_period = min_q;
    assign max_period = max_q;
`else
    assign min_period = '0;
    assign max_period = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: two meter instances (8-bit/TOL 0, 16-bit/TOL 2)
// checked every cycle against an edge-timestamp reference model.
module tb_clk_period_meter;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    logic sig_in = 1'b0;

    logic [7:0]  a_period, a_high, a_min, a_max;
    logic        a_mv, a_lock, a_ovf;
    logic [15:0] b_period, b_high, b_min, b_max;
    logic        b_mv, b_lock, b_ovf;

    always #5 clk_in = ~clk_in;

    clk_period_meter #(
        .CNT_W(8), .EXP_DIV(10), .TOL(0), .LOCK_CNT(4)
    ) u_a (
        .clk_in     (clk_in),
        .rst        (rst),
        .sig_in     (sig_in),
        .period     (a_period),
        .high_time  (a_high),
        .meas_valid (a_mv),
        .locked     (a_lock),
        .overflow   (a_ovf),
        .min_period (a_min),
        .max_period (a_max)
    );

    clk_period_meter #(
        .CNT_W(16), .EXP_DIV(10), .TOL(2), .LOCK_CNT(4)
    ) u_b (
        .clk_in     (clk_in),
        .rst        (rst),
        .sig_in     (sig_in),
        .period     (b_period),
        .high_time  (b_high),
        .meas_valid (b_mv),
        .locked     (b_lock),
        .overflow   (b_ovf),
        .min_period (b_min),
        .max_period (b_max)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: rises/falls timestamped by edge index on raw sig_in.
    // Results show up two edges later (synchroniser latency).
    localparam int EV_NONE = 0;
    localparam int EV_MEAS = 1;
    localparam int EV_HIGH = 2;
    localparam int EV_OVF  = 3;

    int edge_k = 0;
    bit m_prev  [2];
    bit m_armed [2];
    int m_tr    [2];
    int dl0_k [2], dl0_v [2];
    int dl1_k [2], dl1_v [2];
    int e_per [2], e_hi [2], e_mv [2], e_lk [2];
    int e_ov  [2], e_mc [2], e_min [2], e_max [2];

    function automatic int cmax(int i);
        return (i == 0) ? 255 : 65535;
    endfunction

    function automatic int tol(int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset(int i);
        m_prev[i]  = 1'b0;
        m_armed[i] = 1'b0;
        m_tr[i]    = 0;
        dl0_k[i] = EV_NONE; dl0_v[i] = 0;
        dl1_k[i] = EV_NONE; dl1_v[i] = 0;
        e_per[i] = 0; e_hi[i] = 0; e_mv[i] = 0;
        e_lk[i]  = 0; e_ov[i] = 0; e_mc[i] = 0;
        e_min[i] = cmax(i);
        e_max[i] = 0;
    endtask

    task automatic apply_ev(int i, int kind, int v);
        e_mv[i] = 0;
        case (kind)
            EV_MEAS: begin
                e_per[i] = v;
                e_mv[i]  = 1;
                if (iabs(v - 10) <= tol(i)) begin
                    if (e_mc[i] < 4) e_mc[i]++;
                    e_lk[i] = (e_mc[i] >= 4) ? 1 : 0;
                end else begin
                    e_mc[i] = 0;
                    e_lk[i] = 0;
                end
                if (v < e_min[i]) e_min[i] = v;
                if (v > e_max[i]) e_max[i] = v;
            end
            EV_HIGH: e_hi[i] = v;
            EV_OVF: begin
                e_ov[i] = 1;
                e_lk[i] = 0;
                e_mc[i] = 0;
            end
            default: ;
        endcase
    endtask

    task automatic model_edge(int i, bit s, bit r);
        int  ev_k;
        int  ev_v;
        bit  rs;
        bit  fl;
        if (r) begin
            model_reset(i);
            return;
        end
        apply_ev(i, dl1_k[i], dl1_v[i]);
        dl1_k[i] = dl0_k[i];
        dl1_v[i] = dl0_v[i];
        ev_k = EV_NONE;
        ev_v = 0;
        rs = s & ~m_prev[i];
        fl = ~s & m_prev[i];
        if (!m_armed[i]) begin
            if (rs) begin
                m_armed[i] = 1'b1;
                m_tr[i]    = edge_k;
            end
        end else if (rs) begin
            ev_k    = EV_MEAS;
            ev_v    = edge_k - m_tr[i];
            m_tr[i] = edge_k;
        end else if (edge_k - m_tr[i] == cmax(i)) begin
            ev_k       = EV_OVF;
            m_armed[i] = 1'b0;
        end else if (fl) begin
            ev_k = EV_HIGH;
            ev_v = edge_k - m_tr[i];
        end
        dl0_k[i]  = ev_k;
        dl0_v[i]  = ev_v;
        m_prev[i] = s;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                   tag, edge_k, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_period", 32'(a_period), e_per[0]);
        chk("a_high",   32'(a_high),   e_hi[0]);
        chk("a_mv",     32'(a_mv),     e_mv[0]);
        chk("a_locked", 32'(a_lock),   e_lk[0]);
        chk("a_ovf",    32'(a_ovf),    e_ov[0]);
        chk("b_period", 32'(b_period), e_per[1]);
        chk("b_high",   32'(b_high),   e_hi[1]);
        chk("b_mv",     32'(b_mv),     e_mv[1]);
        chk("b_locked", 32'(b_lock),   e_lk[1]);
        chk("b_ovf",    32'(b_ovf),    e_ov[1]);
`ifdef CLK_METER_MINMAX_EN
        chk("a_min", 32'(a_min), e_min[0]);
        chk("a_max", 32'(a_max), e_max[0]);
        chk("b_min", 32'(b_min), e_min[1]);
        chk("b_max", 32'(b_max), e_max[1]);
`else
        chk("a_min", 32'(a_min), 0);
        chk("a_max", 32'(a_max), 0);
        chk("b_min", 32'(b_min), 0);
        chk("b_max", 32'(b_max), 0);
`endif
    endtask

    // Drive one cycle at negedge, sample results at the next negedge
    task automatic step(bit s, bit r);
        sig_in = s;
        rst    = r;
        model_edge(0, s, r);
        model_edge(1, s, r);
        @(posedge clk_in);
        edge_k++;
        @(negedge clk_in);
        check_all();
    endtask

    task automatic seg(int h, int l);
        repeat (h) step(1'b1, 1'b0);
        repeat (l) step(1'b0, 1'b0);
    endtask

    initial begin
        int p;
        int h;
        model_reset(0);
        model_reset(1);
        @(negedge clk_in);

        // Reset held three cycles with sig_in toggling
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        // Divide by 10, 50% duty: lock on the 4th measurement
        repeat (6) seg(5, 5);

        // Switch to /12: A drops lock, B (TOL 2) keeps it
        repeat (3) seg(6, 6);
        repeat (5) seg(5, 5);

        // Held high: A saturates at 255, B measures a long period
        seg(300, 5);
        repeat (5) seg(5, 5);

        // Reset pulsed during the high phase
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        repeat (5) seg(5, 5);

        // Fresh reset, then periods 10, 14, 8 for min/max
        repeat (2) step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);
        seg(5, 5);
        seg(5, 5);
        seg(7, 7);
        seg(4, 4);
        seg(5, 5);

        // Random periods and duty cycles down to the 2-cycle minimum
        repeat (60) begin
            p = int'($urandom_range(2, 25));
            h = int'($urandom_range(1, p - 1));
            seg(h, p - h);
        end
        repeat (4) seg(5, 5);
        repeat (4) step(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
